// File: rtl/muldiv_pkg.sv
// Shared definitions for the mul/div sequencer: state encoding, divide-by-zero
// LO value and the default watchdog limit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MRUN  = 3'd1,
    ST_DRUN  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [31:0] DIV0_LO          = 32'hFFFF_FFFF;
  localparam int unsigned WD_LIMIT_DEFAULT = 48;

  // States in which a unit is busy and the watchdog is counting
  function automatic logic unit_active(input state_e s);
    return (s == ST_MRUN) || (s == ST_DRUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/muldiv_wdog.sv
// Watchdog for the mul/div sequencer: cycle counter, limit compare and sticky
// error flag. Instantiated only when MULDIV_WATCHDOG_EN is defined.
module muldiv_wdog
  import muldiv_pkg::*;
#(
  parameter int unsigned WD_LIMIT = WD_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic active,
  output logic timeout,
  output logic wd_err
);

  localparam int unsigned CW = $clog2(WD_LIMIT + 1);

  logic [CW-1:0] count;

  // timeout fires on the cycle whose closing edge brings the count to WD_LIMIT
  assign timeout = active && (count == CW'(WD_LIMIT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      wd_err <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (active && (count != CW'(WD_LIMIT))) begin
        count <= count + CW'(1);
      end
      if (timeout) begin
        wd_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiplier/divider in EXE. The optional watchdog
// is compiled in with MULDIV_WATCHDOG_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no operation in flight, waiting for a mul/div in EXE
// MRUN     | multiplier running, mult_begin held high
// DRUN     | divider running, div_begin held high
// DONE     | result latched, exe_over high until the pipeline advances
// DRAIN    | EXE flushed, waiting for the running unit to finish
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WD_LIMIT = WD_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic        op_sign,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        exe_allow_out,
  input  logic        flush,
  output logic        mult_begin,
  output logic        div_begin,
  output logic        unit_sign,
  output logic [31:0] unit_op1,
  output logic [31:0] unit_op2,
  input  logic        mult_end,
  input  logic        div_end,
  input  logic [63:0] product,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,
  output logic        exe_over,
  output logic [31:0] hi_result,
  output logic [31:0] lo_result,
  output logic        busy,
  output logic        wd_err
);

  state_e      state;
  state_e      state_nxt;
  logic        run_mul;
  logic        is_muldiv;
  logic        launch_req;
  logic        launch;
  logic        timeout;
  logic        res_we;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;

  assign is_muldiv  = op_mul | op_div;
  assign launch_req = exe_valid & is_muldiv & ~flush;
  assign launch     = (state == ST_IDLE) & launch_req;

`ifdef MULDIV_WATCHDOG_EN
  muldiv_wdog #(
    .WD_LIMIT (WD_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (launch),
    .active  (unit_active(state)),
    .timeout (timeout),
    .wd_err  (wd_err)
  );
`else
  logic [31:0] unused_wd_limit;

  assign unused_wd_limit = 32'(WD_LIMIT);
  assign timeout         = 1'b0;
  assign wd_err          = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    res_we    = 1'b0;
    hi_nxt    = hi_result;
    lo_nxt    = lo_result;
    case (state)
      ST_IDLE: begin
        if (launch_req) begin
          if (op_mul) begin
            state_nxt = ST_MRUN;
          end else if (src2 == 32'd0) begin
            // divide-by-zero resolves here, the divider is never started
            state_nxt = ST_DONE;
            res_we    = 1'b1;
            hi_nxt    = src1;
            lo_nxt    = DIV0_LO;
          end else begin
            state_nxt = ST_DRUN;
          end
        end
      end
      ST_MRUN: begin
        if (flush) begin
          state_nxt = (mult_end || timeout) ? ST_IDLE : ST_DRAIN;
        end else if (mult_end) begin
          state_nxt = ST_DONE;
          res_we    = 1'b1;
          hi_nxt    = product[63:32];
          lo_nxt    = product[31:0];
        end else if (timeout) begin
          state_nxt = ST_DONE;
          res_we    = 1'b1;
          hi_nxt    = 32'd0;
          lo_nxt    = 32'd0;
        end
      end
      ST_DRUN: begin
        if (flush) begin
          state_nxt = (div_end || timeout) ? ST_IDLE : ST_DRAIN;
        end else if (div_end) begin
          state_nxt = ST_DONE;
          res_we    = 1'b1;
          hi_nxt    = remainder;
          lo_nxt    = quotient;
        end else if (timeout) begin
          state_nxt = ST_DONE;
          res_we    = 1'b1;
          hi_nxt    = 32'd0;
          lo_nxt    = 32'd0;
        end
      end
      ST_DRAIN: begin
        if ((run_mul ? mult_end : div_end) || timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (flush || exe_allow_out) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_mul   <= 1'b0;
      unit_sign <= 1'b0;
      unit_op1  <= 32'd0;
      unit_op2  <= 32'd0;
    end else if (launch) begin
      run_mul   <= op_mul;
      unit_sign <= op_sign;
      unit_op1  <= src1;
      unit_op2  <= src2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_result <= 32'd0;
      lo_result <= 32'd0;
    end else if (res_we) begin
      hi_result <= hi_nxt;
      lo_result <= lo_nxt;
    end
  end

  // begin stays up through DRAIN so the unit is never abandoned mid-operation
  assign mult_begin = (state == ST_MRUN) | ((state == ST_DRAIN) & run_mul);
  assign div_begin  = (state == ST_DRUN) | ((state == ST_DRAIN) & ~run_mul);
  assign busy       = (state != ST_IDLE);
  assign exe_over   = exe_valid & ~flush & (~is_muldiv | (state == ST_DONE));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: table of complete mul/div operations plus
// hand-written flush, reset and watchdog sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_valid, op_mul, op_div, op_sign;
  logic [31:0] src1, src2;
  logic        exe_allow_out, flush;
  logic        mult_begin, div_begin, unit_sign;
  logic [31:0] unit_op1, unit_op2;
  logic        mult_end, div_end;
  logic [63:0] product;
  logic [31:0] quotient, remainder;
  logic        exe_over;
  logic [31:0] hi_result, lo_result;
  logic        busy, wd_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi, last_lo;

  muldiv_ctrl #(.WD_LIMIT(48)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .exe_valid     (exe_valid),
    .op_mul        (op_mul),
    .op_div        (op_div),
    .op_sign       (op_sign),
    .src1          (src1),
    .src2          (src2),
    .exe_allow_out (exe_allow_out),
    .flush         (flush),
    .mult_begin    (mult_begin),
    .div_begin     (div_begin),
    .unit_sign     (unit_sign),
    .unit_op1      (unit_op1),
    .unit_op2      (unit_op2),
    .mult_end      (mult_end),
    .div_end       (div_end),
    .product       (product),
    .quotient      (quotient),
    .remainder     (remainder),
    .exe_over      (exe_over),
    .hi_result     (hi_result),
    .lo_result     (lo_result),
    .busy          (busy),
    .wd_err        (wd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_mul;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          hold;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exe_valid     = 1'b0;
    op_mul        = 1'b0;
    op_div        = 1'b0;
    flush         = 1'b0;
    exe_allow_out = 1'b0;
    mult_end      = 1'b0;
    div_end       = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exe_valid = 1'b1;
    op_mul = v.is_mul; op_div = !v.is_mul; op_sign = v.sign;
    src1 = v.a; src2 = v.b; exe_allow_out = 1'b0;
    #1;
    chk($sformatf("%s idle exe_over", v.name), exe_over, 0);
    tick();
    chk($sformatf("%s unit_op1", v.name), unit_op1, v.a);
    chk($sformatf("%s unit_op2", v.name), unit_op2, v.b);
    chk($sformatf("%s unit_sign", v.name), unit_sign, v.sign);
    src1 = ~v.a; src2 = v.b ^ 32'h5A5A_0001;
    if (v.lat == 0) begin
      #1;
      chk($sformatf("%s div0 div_begin", v.name), div_begin, 0);
      chk($sformatf("%s div0 mult_begin", v.name), mult_begin, 0);
    end else begin
      for (int j = 1; j <= v.lat; j++) begin
        mult_end = 1'b0; div_end = 1'b0;
        if (j == 1 && v.lat > 1) begin
          if (v.is_mul) div_end = 1'b1; else mult_end = 1'b1;
          product = 64'hDEAD_BEEF_0BAD_F00D; quotient = 32'h1111_2222; remainder = 32'h3333_4444;
        end
        if (j == v.lat) begin
          if (v.is_mul) mult_end = 1'b1; else div_end = 1'b1;
          product = v.prod; quotient = v.quo; remainder = v.rem;
        end
        #1;
        chk($sformatf("%s run mult_begin c%0d", v.name, j), mult_begin, v.is_mul);
        chk($sformatf("%s run div_begin c%0d", v.name, j), div_begin, !v.is_mul);
        chk($sformatf("%s run exe_over c%0d", v.name, j), exe_over, 0);
        tick();
      end
      mult_end = 1'b0; div_end = 1'b0;
      product = ~v.prod; quotient = ~v.quo; remainder = ~v.rem;
      #1;
      chk($sformatf("%s done begins", v.name), {mult_begin, div_begin}, 0);
      chk($sformatf("%s unit_op1 stable", v.name), unit_op1, v.a);
    end
    chk($sformatf("%s exe_over", v.name), exe_over, 1);
    chk($sformatf("%s hi", v.name), hi_result, v.exp_hi);
    chk($sformatf("%s lo", v.name), lo_result, v.exp_lo);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk($sformatf("%s hold exe_over h%0d", v.name, h), exe_over, 1);
      chk($sformatf("%s hold hi/lo h%0d", v.name, h), {hi_result, lo_result}, {v.exp_hi, v.exp_lo});
    end
    exe_allow_out = 1'b1;
    #1;
    chk($sformatf("%s leave exe_over", v.name), exe_over, 1);
    tick();
    idle_inputs();
    #1;
    chk($sformatf("%s idle after leave", v.name), busy, 0);
    chk($sformatf("%s exe_over after leave", v.name), exe_over, 0);
    last_hi = v.exp_hi; last_lo = v.exp_lo;
  endtask

  initial begin
    vecs[0] = '{"mult_neg", 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 33, 64'hFFFF_FFFF_FFFF_FFFA,
                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0};
    vecs[1] = '{"divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 10, 64'd0,
                32'd14, 32'd2, 32'd2, 32'd14, 5};
    vecs[2] = '{"div_by_zero", 1'b0, 1'b1, 32'd1234, 32'd0, 0, 64'd0,
                32'h55, 32'h66, 32'd1234, 32'hFFFF_FFFF, 2};
    vecs[3] = '{"multu_max", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001,
                32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001, 0};
    vecs[4] = '{"div_neg7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5, 64'd0,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1};

    idle_inputs();
    resetn = 1'b0; op_sign = 1'b0; src1 = 32'd0; src2 = 32'd0;
    product = 64'd0; quotient = 32'd0; remainder = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset begins", {mult_begin, div_begin}, 0);
    chk("reset unit ops", {unit_sign, unit_op1, unit_op2}, 0);
    chk("reset hi/lo", {hi_result, lo_result}, 0);
    chk("reset wd_err", wd_err, 0);
    chk("reset exe_over", exe_over, 0);
    resetn = 1'b1;
    tick();

    // non-mul/div instruction completes immediately unless flushed
    exe_valid = 1'b1; #1;
    chk("plain exe_over", exe_over, 1);
    flush = 1'b1; #1;
    chk("plain flushed exe_over", exe_over, 0);
    idle_inputs();
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // flush four cycles into DRUN, then a MULT waits behind the drain
    exe_valid = 1'b1; op_div = 1'b1; op_sign = 1'b0; src1 = 32'd50; src2 = 32'd5;
    tick();
    repeat (3) tick();
    flush = 1'b1; #1;
    chk("flush drun exe_over", exe_over, 0);
    tick();
    flush = 1'b0; op_div = 1'b0; op_mul = 1'b1; src1 = 32'd6; src2 = 32'd7;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("drain div_begin c%0d", j), {div_begin, mult_begin, busy}, 3'b101);
      chk($sformatf("drain exe_over c%0d", j), exe_over, 0);
      if (j < 2) tick();
    end
    div_end = 1'b1; quotient = 32'd99; remainder = 32'd98;
    #1;
    chk("drain unit_op1 held", unit_op1, 50);
    tick();
    div_end = 1'b0; #1;
    chk("drain exit idle", {busy, div_begin, mult_begin, exe_over}, 0);
    chk("drain results kept", {hi_result, lo_result}, {last_hi, last_lo});
    tick();
    chk("post-drain mult launch", mult_begin, 1);
    chk("post-drain ops", {unit_op1, unit_op2}, {32'd6, 32'd7});
    tick();
    mult_end = 1'b1; product = 64'd42;
    tick();
    mult_end = 1'b0; #1;
    chk("post-drain result", {hi_result, lo_result, exe_over}, {32'd0, 32'd42, 1'b1});
    exe_allow_out = 1'b1;
    tick();
    idle_inputs(); #1;
    chk("post-drain idle", busy, 0);
    last_hi = 32'd0; last_lo = 32'd42;

    // flush coinciding with mult_end discards the result
    exe_valid = 1'b1; op_mul = 1'b1; src1 = 32'd3; src2 = 32'd3;
    tick();
    tick();
    flush = 1'b1; mult_end = 1'b1; product = 64'h1234_5678_9ABC_DEF0;
    tick();
    idle_inputs(); #1;
    chk("flush+end idle", {busy, mult_begin}, 0);
    chk("flush+end discarded", {hi_result, lo_result}, {last_hi, last_lo});

    // flush together with exe_allow_out in DONE
    exe_valid = 1'b1; op_div = 1'b1; src1 = 32'd77; src2 = 32'd0;
    tick();
    chk("div0 77 result", {hi_result, lo_result, exe_over}, {32'd77, 32'hFFFF_FFFF, 1'b1});
    flush = 1'b1; exe_allow_out = 1'b1; #1;
    chk("done flush exe_over", exe_over, 0);
    tick();
    idle_inputs(); #1;
    chk("done flush idle", busy, 0);

    // asynchronous reset during MRUN, then a stray mult_end
    exe_valid = 1'b1; op_mul = 1'b1; op_sign = 1'b1; src1 = 32'd11; src2 = 32'd13;
    tick();
    tick();
    chk("pre-reset mult_begin", {mult_begin, unit_sign}, 2'b11);
    exe_valid = 1'b0; op_mul = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("async reset state", {busy, mult_begin, div_begin, exe_over, wd_err}, 0);
    chk("async reset unit", {unit_sign, unit_op1, unit_op2}, 0);
    chk("async reset hi/lo", {hi_result, lo_result}, 0);
    tick();
    resetn = 1'b1;
    mult_end = 1'b1; product = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mult_end = 1'b0; #1;
    chk("stray end ignored", {busy, hi_result, lo_result}, 0);

`ifdef MULDIV_WATCHDOG_EN
    exe_valid = 1'b1; op_div = 1'b1; src1 = 32'd5; src2 = 32'd0;
    tick();
    exe_allow_out = 1'b1;
    tick();
    idle_inputs();
    exe_valid = 1'b1; op_mul = 1'b1; src1 = 32'd9; src2 = 32'd9;
    tick();
    repeat (47) tick();
    chk("wdog before limit", {mult_begin, wd_err, exe_over}, 3'b100);
    tick();
    chk("wdog fired", {wd_err, exe_over, busy, mult_begin}, 4'b1110);
    chk("wdog zero result", {hi_result, lo_result}, 0);
    exe_allow_out = 1'b1;
    tick();
    idle_inputs(); #1;
    chk("wdog idle sticky", {busy, wd_err}, 2'b01);
`else
    exe_valid = 1'b1; op_mul = 1'b1; src1 = 32'd9; src2 = 32'd9;
    tick();
    repeat (60) tick();
    chk("no wdog still running", {mult_begin, wd_err, exe_over}, 3'b100);
    mult_end = 1'b1; product = 64'd81;
    tick();
    mult_end = 1'b0; #1;
    chk("no wdog late result", {hi_result, lo_result, exe_over}, {32'd0, 32'd81, 1'b1});
    exe_allow_out = 1'b1;
    tick();
    idle_inputs(); #1;
    chk("no wdog idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the iterative multiplier and divider used by the execute stage of the five-stage pipeline. It launches one MULT/MULTU/DIV/DIVU per EXE instruction, holds stable operands and a level start into the unit until it signals completion, and latches the 64-bit HI/LO result. It raises the execute-complete signal and holds the result until the pipeline advances. It also drains an in-flight operation after a pipeline flush, and resolves divide-by-zero without using the divider.

## Interface
- WD_LIMIT, 48: watchdog cycle limit in RUN/DRAIN; only used when the watchdog is compiled in.
- clk  in  1  clock
- resetn  in  1  asynchronous reset, active low
- exe_valid  in  1  EXE holds a valid instruction
- op_mul, op_div  in  1 each  instruction is multiply or divide; never both high
- op_sign  in  1  signed operation, forwarded to the unit
- src1, src2  in  32 each  operands; src2 is the divisor
- exe_allow_out  in  1  MEM accepts the EXE instruction this cycle
- flush  in  1  exception/ERET cancels the EXE instruction
- mult_begin, div_begin  out  1 each  level start to the multiplier or divider
- unit_sign  out  1  latched sign
- unit_op1, unit_op2  out  32 each  latched operands to both units
- mult_end, div_end  in  1 each  completion pulse from the unit
- product  in  64  multiplier result
- quotient, remainder  in  32 each  divider result
- exe_over  out  1  EXE instruction complete
- hi_result, lo_result  out  32 each  HI (high product or remainder), LO (low product or quotient)
- busy  out  1  state not IDLE
- wd_err  out  1  sticky watchdog error

## Operation
- States: IDLE, MRUN, DRUN, DONE, DRAIN.
- IDLE launch condition: exe_valid & (op_mul|op_div) & !flush.
  - On launch, latch src1, src2 and op_sign into unit_op1, unit_op2 and unit_sign.
  - op_mul → MRUN.
  - op_div with src2≠0 → DRUN.
  - op_div with src2==0 → DONE, with hi_result=src1 and lo_result=32'hFFFF_FFFF. No div_begin is issued.
- MRUN / DRUN:
  - mult_begin=1 in MRUN; div_begin=1 in DRUN.
  - On the matching *_end, capture the result into hi_result/lo_result and go to DONE.
  - flush without *_end → DRAIN.
  - flush coinciding with *_end → IDLE; the result is discarded.
- DRAIN: the begin signal stays high for the unit that was running. Its *_end moves the block to IDLE. hi_result/lo_result are not updated.
- DONE:
  - exe_allow_out → IDLE.
  - flush → IDLE; flush has priority over exe_allow_out.
  - Otherwise stay in DONE, holding the result.
- exe_over = exe_valid & !flush & (!(op_mul|op_div) | state==DONE).
  - It is 0 in IDLE for a mul/div instruction, and 0 in RUN and DRAIN.
  - A mul/div arriving while the block is in DRAIN stalls and launches on the first IDLE cycle.
- unit_op* and unit_sign change only on launch. hi_result/lo_result change only on capture or on the divide-by-zero path.

## Timing
- Reset (async, resetn=0):
  - state=IDLE.
  - mult_begin=div_begin=0, unit_sign=0, unit_op1=unit_op2=0.
  - hi_result=lo_result=0, busy=0, wd_err=0, watchdog count=0.
  - exe_over=0 while exe_valid=0.
- Reset mid-operation aborts immediately. Any later *_end arriving in IDLE is ignored.
- Launch at edge T. Begin is high from T+1. With *_end at edge T+k, the result is valid and exe_over=1 from T+k+1.
- Divide-by-zero: exe_over=1 from T+1.
- The instruction leaves on the first DONE cycle with exe_allow_out=1. The block is in IDLE on the next cycle, so back-to-back mul/div costs no extra bubble beyond the unit latency.
- *_end received for the other unit, or in IDLE/DONE, is ignored.

## Configuration
- MULDIV_WATCHDOG_EN defined:
  - A counter clears on launch and increments each cycle in MRUN, DRUN or DRAIN.
  - When the count reaches WD_LIMIT, wd_err sets until reset.
  - MRUN/DRUN then force DONE with hi_result=lo_result=0. DRAIN is forced to IDLE.
  - Begin drops on the forced transition.
- MULDIV_WATCHDOG_EN undefined: no counter, wd_err tied to 0, and RUN/DRAIN wait indefinitely.

## Structure
- Shared package muldiv_pkg holds:
  - the state encoding (3-bit enum);
  - DIV0_LO=32'hFFFF_FFFF;
  - the default WD_LIMIT.
- One sub-module, muldiv_wdog: counter, compare and sticky wd_err, instantiated only under MULDIV_WATCHDOG_EN.

## Test plan
- MULT, src1=32'hFFFF_FFFE (−2), src2=3, unit end after 33 cycles, exe_allow_out=1 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, exe_over for exactly 1 cycle, IDLE next cycle.
- DIVU 100/7 → lo=14, hi=2. Holding exe_allow_out=0 for 5 cycles keeps DONE and exe_over high, with results stable.
- DIV with src2=0 and src1=1234 → next cycle hi=1234, lo=FFFF_FFFF, exe_over=1, div_begin never high.
- flush 4 cycles into DRUN → DRAIN with div_begin held. A new MULT then waits with exe_over=0, launches the cycle after div_end, and old results are unchanged.
- resetn low during MRUN → all outputs at reset values asynchronously. A subsequent stray mult_end is ignored.
- With MULDIV_WATCHDOG_EN and WD_LIMIT=48, a unit that never ends → wd_err=1 and DONE 48 cycles after entering MRUN, with hi=lo=0.
